b_pc_unit: RTL and testbench

Parametrised next-generation program counter for the single-cycle MIPS-style core. It adds several features on top of the basic sequential/jump counter:
- sequential fetch, PC-relative branch, pseudo-direct jump and register-indirect jump;
- a pipeline stall input;
- an optional hardware return-address stack (RAS) for call/return prediction-free linking.

It sits between the control decoder and the instruction memory address port.

---
 rtl/b_pc_pkg.sv | 30 +++
 rtl/b_pc_unit_if.sv | 32 +++
 rtl/b_pc_unit_ras.sv | 58 +++++
 rtl/b_pc_unit.sv | 107 ++++++++++
 tb/tb_b_pc_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/b_pc_pkg.sv
// Shared types and helpers for the b_pc_unit program counter.
// Holds the next-PC source encoding and the pseudo-direct jump target helper.
package b_pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_RET
    } pc_sel_t;

    localparam int PC_STEP = 4;

    // Keeps the upper (op_w-2) bits of pc4 and fills the rest with imm<<2.
    // Operates on 64-bit containers so one helper serves every WIDTH.
    function automatic logic [63:0] jump_target(
        input logic [63:0] pc4,
        input logic [63:0] imm,
        input int          width,
        input int          op_w
    );
        logic [63:0] lo_mask;
        logic [63:0] full_mask;
        lo_mask   = (64'd1 << (width - op_w + 2)) - 64'd1;
        full_mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (pc4 & full_mask & ~lo_mask) | ((imm << 2) & lo_mask);
    endfunction

endpackage

// File: rtl/b_pc_unit_if.sv
// Request/status bundle between the control decoder and b_pc_unit.
interface b_pc_unit_if #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 6,
    parameter int IMM_W = 16
);

    logic                  stall;
    logic                  branch;
    logic [IMM_W-1:0]      branch_off;
    logic                  jump;
    logic [WIDTH-OP_W-1:0] imm;
    logic                  jump_reg;
    logic [WIDTH-1:0]      reg_target;
    logic                  link;
    logic                  ret;
    logic [WIDTH-1:0]      pc;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  ras_err;

    modport master (
        output stall, branch, branch_off, jump, imm, jump_reg, reg_target, link, ret,
        input  pc, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  stall, branch, branch_off, jump, imm, jump_reg, reg_target, link, ret,
        output pc, ras_empty, ras_full, ras_err
    );

endinterface

// File: rtl/b_pc_unit_ras.sv
// b_ras: circular return-address stack with a saturating occupancy count.
// A push into a full stack overwrites the oldest entry; misuse sets a sticky err.
module b_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    // ptr always names the next slot to write; when full that slot is the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
            if (full) begin
                err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[ptr] <= din;
        end
    end

    assign top   = mem[ptr - 1'b1];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(RAS_DEPTH));

endmodule

// File: rtl/b_pc_unit.sv
// b_pc_unit: program counter with branch, jump, register jump and stall.
// Define PC_RAS_EN to build the return-address stack (link/ret support).
module b_pc_unit
    import b_pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               OP_W         = 6,
    parameter int               IMM_W        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 8
) (
    input logic         clk,
    input logic         reset,
    b_pc_unit_if.slave  bus
);

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] j_target;
    pc_sel_t          sel;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_err;

    assign pc4       = pc_q + WIDTH'(PC_STEP);
    assign br_off    = WIDTH'({{(WIDTH-IMM_W){bus.branch_off[IMM_W-1]}}, bus.branch_off}) << 2;
    assign jr_target = {bus.reg_target[WIDTH-1:2], 2'b00};
    assign j_target  = WIDTH'(jump_target(64'(pc4), 64'(bus.imm), WIDTH, OP_W));

    // Priority resolution; ret only competes when the stack is built.
    always_comb begin
        sel = SEL_SEQ;
        if (RAS_ON && bus.ret) begin
            sel = SEL_RET;
        end else if (bus.jump_reg) begin
            sel = SEL_JR;
        end else if (bus.jump) begin
            sel = SEL_J;
        end else if (bus.branch) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = pc4;
        case (sel)
            SEL_SEQ: pc_next = pc4;
            SEL_BR:  pc_next = pc4 + br_off;
            SEL_J:   pc_next = j_target;
            SEL_JR:  pc_next = jr_target;
            SEL_RET: pc_next = ras_empty ? pc4 : ras_top;
            default: pc_next = pc4;
        endcase
    end

    // A stalled cycle must not touch the stack, so both strobes are gated here.
    assign push = RAS_ON && !bus.stall && bus.link && ((sel == SEL_J) || (sel == SEL_JR));
    assign pop  = !bus.stall && (sel == SEL_RET);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else if (!bus.stall) begin
            pc_q <= pc_next;
        end
    end

`ifdef PC_RAS_EN
    b_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .err   (ras_err)
    );
`else
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    assign bus.pc        = pc_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = ras_err;

endmodule

// File: tb/tb_b_pc_unit.sv
// Bench for b_pc_unit: directed literal checks plus randomized traffic against a queue-based model.
module tb_b_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   started;

    b_pc_unit_if #(.WIDTH(32), .OP_W(6), .IMM_W(16)) bus ();

    b_pc_unit #(
        .WIDTH        (32),
        .OP_W         (6),
        .IMM_W        (16),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: PC as an integer, stack as a queue (back = most recent).
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    bit          m_err;

    always @(posedge clk) begin
        logic [31:0] pc4;
        logic [31:0] nxt;
        bit          do_push;
        pc4     = m_pc + 32'd4;
        nxt     = pc4;
        do_push = 1'b0;
        if (reset) begin
            m_pc = 32'h0;
            m_stack.delete();
            m_err = 1'b0;
        end else if (!bus.stall) begin
            if (RAS_ON && bus.ret) begin
                if (m_stack.size() > 0) nxt = m_stack.pop_back();
                else m_err = 1'b1;
            end else if (bus.jump_reg) begin
                nxt     = bus.reg_target & 32'hFFFF_FFFC;
                do_push = RAS_ON && bus.link;
            end else if (bus.jump) begin
                nxt     = (pc4 & 32'hF000_0000) | (32'(bus.imm) * 32'd4);
                do_push = RAS_ON && bus.link;
            end else if (bus.branch) begin
                nxt = pc4 + 32'($signed(bus.branch_off) * 4);
            end
            if (do_push) begin
                if (m_stack.size() == DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_stack.push_back(pc4);
            end
            m_pc = nxt;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_output("model_pc", bus.pc, m_pc);
            check_output("model_empty", 32'(bus.ras_empty), 32'(m_stack.size() == 0));
            check_output("model_full", 32'(bus.ras_full), 32'(m_stack.size() == DEPTH));
            check_output("model_err", 32'(bus.ras_err), 32'(m_err));
        end
    end

    task automatic idle_inputs();
        bus.stall      = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_off = '0;
        bus.jump       = 1'b0;
        bus.imm        = '0;
        bus.jump_reg   = 1'b0;
        bus.reg_target = '0;
        bus.link       = 1'b0;
        bus.ret        = 1'b0;
    endtask

    // Holds the currently driven request for one edge, then clears it.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic do_jr(input logic [31:0] t);
        bus.jump_reg   = 1'b1;
        bus.reg_target = t;
        apply_stimulus();
    endtask

    task automatic do_jump(input logic [25:0] i, input bit lnk);
        bus.jump = 1'b1;
        bus.imm  = i;
        bus.link = lnk;
        apply_stimulus();
    endtask

    task automatic do_ret();
        bus.ret = 1'b1;
        apply_stimulus();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        started     = 1'b0;
        m_pc        = 32'h0;
        m_err       = 1'b0;
        reset       = 1'b1;
        idle_inputs();
        reset = 1'b1;
        apply_stimulus();
        started = 1'b1;
        check_output("reset_pc", bus.pc, 32'h0);
        check_output("reset_empty", 32'(bus.ras_empty), 32'd1);
        check_output("reset_full", 32'(bus.ras_full), 32'd0);
        check_output("reset_err", 32'(bus.ras_err), 32'd0);

        for (int i = 1; i <= 3; i++) begin
            apply_stimulus();
            check_output("seq_pc", bus.pc, 32'(4 * i));
        end

        do_jr(32'h100);
        bus.branch = 1'b1; bus.branch_off = 16'hFFFE;
        apply_stimulus();
        check_output("branch_back", bus.pc, 32'h0000_00FC);
        do_jr(32'hFFFF_FFFC);
        bus.branch = 1'b1; bus.branch_off = 16'h7FFF;
        apply_stimulus();
        check_output("branch_wrap", bus.pc, 32'h0001_FFFC);

        do_jr(32'h1000_0004);
        do_jump(26'h40, 1'b0);
        check_output("jump_pseudo", bus.pc, 32'h1000_0100);
        do_jr(32'h2003);
        check_output("jump_reg", bus.pc, 32'h2000);

        do_jr(32'h40);
        do_jump(26'h80, 1'b1);
        check_output("call_pc", bus.pc, 32'h200);
        do_ret();
        check_output("ret_pc", bus.pc, RAS_ON ? 32'h44 : 32'h204);
        check_output("ret_empty", 32'(bus.ras_empty), 32'd1);
        do_ret();
        check_output("underflow_pc", bus.pc, RAS_ON ? 32'h48 : 32'h208);
        check_output("underflow_err", 32'(bus.ras_err), 32'(RAS_ON));

        reset = 1'b1;
        apply_stimulus();
        for (int k = 1; k <= 9; k++) do_jump(26'(32'h100 * k), 1'b1);
        check_output("ovf_full", 32'(bus.ras_full), 32'(RAS_ON));
        check_output("ovf_err", 32'(bus.ras_err), 32'(RAS_ON));
        for (int j = 0; j < 8; j++) begin
            do_ret();
            check_output("lifo_pc", bus.pc, RAS_ON ? 32'(32'h400 * (8 - j) + 4) : 32'(32'h2404 + 4 * j));
        end
        check_output("drained_empty", 32'(bus.ras_empty), 32'd1);

        for (int s = 0; s < 2; s++) begin
            bus.stall = 1'b1; bus.jump = 1'b1; bus.imm = 26'h3FF;
            apply_stimulus();
            check_output("stall_hold", bus.pc, RAS_ON ? 32'h404 : 32'h2420);
        end

        do_jump(26'h100, 1'b1);
        do_jump(26'h200, 1'b1);
        bus.ret = 1'b1; bus.jump = 1'b1; bus.link = 1'b1; bus.imm = 26'h300;
        apply_stimulus();
        check_output("ret_wins_pc", bus.pc, RAS_ON ? 32'h404 : 32'hC00);
        check_output("ret_wins_empty", 32'(bus.ras_empty), 32'(!RAS_ON));
        bus.ret = 1'b1; bus.jump = 1'b1; bus.link = 1'b1; bus.imm = 26'h300;
        reset = 1'b1;
        apply_stimulus();
        check_output("reset_wins_pc", bus.pc, 32'h0);
        check_output("reset_wins_empty", 32'(bus.ras_empty), 32'd1);

        for (int n = 0; n < 3000; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            bus.stall      = ($urandom_range(0, 7) == 0);
            bus.branch     = ($urandom_range(0, 3) == 0);
            bus.branch_off = 16'($urandom);
            bus.jump       = ($urandom_range(0, 4) == 0);
            bus.imm        = 26'($urandom);
            bus.jump_reg   = ($urandom_range(0, 6) == 0);
            bus.reg_target = $urandom;
            bus.link       = ($urandom_range(0, 1) == 0);
            bus.ret        = ($urandom_range(0, 4) == 0);
            apply_stimulus();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
